// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch, decode, address generation,
// execute, memory access and writeback over the shared ALU and memory port.
module multicycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_type_sel,
  output logic [1:0] imm_sel,
  output logic       instr_retired,
  output logic       illegal_op
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    StFetch    = STATE_W'(0),
    StDecode   = STATE_W'(1),
    StMemAdr   = STATE_W'(2),
    StMemRead  = STATE_W'(3),
    StMemWb    = STATE_W'(4),
    StMemWrite = STATE_W'(5),
    StExecR    = STATE_W'(6),
    StExecI    = STATE_W'(7),
    StAluWb    = STATE_W'(8),
    StBranch   = STATE_W'(9),
    StJal      = STATE_W'(10),
    StTrap     = STATE_W'(11)
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q;
  // Outputs decode from this, so reset shows FETCH mux selects immediately.
  state_e state_eff;

  // Next-state logic.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        unique case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJal:      state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  // State register and sticky trap flag, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode && state_d == StTrap) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign state_eff = reset ? StFetch : state_q;

  // Datapath controls decoded from the current state; strobes masked by reset.
  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_type_sel  = 2'b00;
    instr_retired = 1'b0;
    unique case (state_eff)
      StFetch: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      StMemWrite: begin
        adr_src       = 1'b1;
        mem_write     = 1'b1;
        instr_retired = mem_ready;
      end
      StExecR: begin
        alu_src_a    = 2'b10;
        alu_type_sel = 2'b01;
      end
      StExecI: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        alu_type_sel = 2'b01;
      end
      StAluWb: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 2'b10;
        alu_type_sel  = 2'b10;
        pc_write      = branch_taken;
        instr_retired = 1'b1;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
    end
  end

  assign illegal_op = illegal_q & ~reset;

  // Immediate format follows the opcode alone.
  always_comb begin
    imm_sel = 2'b00;
    unique case (opcode)
      OpStore:  imm_sel = 2'b01;
      OpBranch: imm_sel = 2'b10;
      OpJal:    imm_sel = 2'b11;
      default:  imm_sel = 2'b00;
    endcase
  end

endmodule
